// File: rtl/knob_pkg.sv
// Shared types and timing constants for the front-panel scanner and its MCP3008 transfer engine.
// A slot is 38 dclk half-periods: 1 setup half, 34 shift halves (17 dclk periods), 3 gap halves.
package knob_pkg;

    localparam int NUM_KNOBS = 12;
    localparam int KNOB_W    = 10;

    typedef enum logic [3:0] {
        KNOB_VOLUME          = 4'd0,
        KNOB_PITCH           = 4'd1,
        KNOB_DELAY_WET       = 4'd2,
        KNOB_DELAY_RATE      = 4'd3,
        KNOB_DELAY_FEEDBACK  = 4'd4,
        KNOB_REVERB_WET      = 4'd5,
        KNOB_REVERB_SIZE     = 4'd6,
        KNOB_REVERB_FEEDBACK = 4'd7,
        KNOB_FILTER_QUALITY  = 4'd8,
        KNOB_FILTER_CUTOFF   = 4'd9,
        KNOB_DIST_DRIVE      = 4'd10,
        KNOB_CRUSH_PRESSURE  = 4'd11
    } knob_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP
    } xfer_state_e;

    localparam int SLOT_HALVES = 38;

    // Half indices within a slot; dclk rising edge j starts half 2j-1.
    localparam logic [5:0] SHIFT_LAST_HALF   = 6'd34;
    localparam logic [5:0] SLOT_LAST_HALF    = 6'd37;
    localparam logic [5:0] CMD_END_HALF      = 6'd10;
    localparam logic [5:0] FIRST_SAMPLE_HALF = 6'd15;
    localparam logic [5:0] LAST_SAMPLE_HALF  = 6'd33;

    // Start bit followed by the single-ended select bit.
    localparam logic [1:0] CMD_PREFIX = 2'b11;

    function automatic logic cmd_bit(input logic [2:0] channel, input logic [2:0] idx);
        logic bit_val;
        case (idx)
            3'd0:    bit_val = CMD_PREFIX[1];
            3'd1:    bit_val = CMD_PREFIX[0];
            3'd2:    bit_val = channel[2];
            3'd3:    bit_val = channel[1];
            3'd4:    bit_val = channel[0];
            default: bit_val = 1'b0;
        endcase
        return bit_val;
    endfunction

    function automatic int frame_cycles(input int half_period);
        return NUM_KNOBS * SLOT_HALVES * half_period;
    endfunction

endpackage

// File: rtl/mcp3008_xfer.sv
// One MCP3008 conversion per slot: setup, 17 dclk periods of command/data, then a CS-high gap.
// All SPI pins are registered from the next-state values so they change exactly at half boundaries.
module mcp3008_xfer
    import knob_pkg::*;
#(
    parameter int HALF_PERIOD = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dev_sel,
    input  logic [2:0]        channel,
    input  logic              cipo,
    output logic [KNOB_W-1:0] result,
    output logic              done,
    output logic              copi,
    output logic              dclk,
    output logic              cs0,
    output logic              cs1
);

    localparam int HP_W = $clog2(HALF_PERIOD + 1);

    xfer_state_e       state_q, state_n;
    logic [HP_W-1:0]   hp_q, hp_n;
    logic [5:0]        half_q, half_n;
    logic              dev_q, dev_n;
    logic [2:0]        chan_q, chan_n;
    logic [KNOB_W-1:0] shift_q;
    logic              half_end;
    logic              launch;
    logic              cs_low_n;
    logic              dclk_n;
    logic              copi_n;
    logic              sample;

    assign half_end = (hp_q == HP_W'(HALF_PERIOD - 1));
    assign result   = shift_q;

    always_comb begin
        state_n = state_q;
        hp_n    = hp_q;
        half_n  = half_q;
        dev_n   = dev_q;
        chan_n  = chan_q;
        launch  = 1'b0;

        if (state_q != ST_IDLE) begin
            hp_n = half_end ? '0 : hp_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                launch = start;
            end
            ST_SETUP: begin
                if (half_end) begin
                    state_n = ST_SHIFT;
                    half_n  = 6'd1;
                end
            end
            ST_SHIFT: begin
                if (half_end) begin
                    half_n = half_q + 6'd1;
                    if (half_q == SHIFT_LAST_HALF) begin
                        state_n = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (half_end) begin
                    if (half_q == SLOT_LAST_HALF) begin
                        launch  = start;
                        state_n = ST_IDLE;
                    end else begin
                        half_n = half_q + 6'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Device and channel are captured once per slot so k may advance mid-slot.
        if (launch) begin
            state_n = ST_SETUP;
            half_n  = '0;
            hp_n    = '0;
            dev_n   = dev_sel;
            chan_n  = channel;
        end

        cs_low_n = (state_n == ST_SETUP) || (state_n == ST_SHIFT);
        dclk_n   = (state_n == ST_SHIFT) && half_n[0];
        copi_n   = (cs_low_n && (half_n < CMD_END_HALF)) ? cmd_bit(chan_n, half_n[3:1]) : 1'b0;
        sample   = dclk_n && !dclk && (half_n >= FIRST_SAMPLE_HALF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hp_q    <= '0;
            half_q  <= '0;
            dev_q   <= 1'b0;
            chan_q  <= '0;
            shift_q <= '0;
            done    <= 1'b0;
            cs0     <= 1'b1;
            cs1     <= 1'b1;
            dclk    <= 1'b0;
            copi    <= 1'b0;
        end else begin
            state_q <= state_n;
            hp_q    <= hp_n;
            half_q  <= half_n;
            dev_q   <= dev_n;
            chan_q  <= chan_n;
            cs0     <= !(cs_low_n && !dev_n);
            cs1     <= !(cs_low_n && dev_n);
            dclk    <= dclk_n;
            copi    <= copi_n;
            done    <= sample && (half_n == LAST_SAMPLE_HALF);
            if (sample) begin
                shift_q <= {shift_q[KNOB_W-2:0], cipo};
            end
        end
    end

endmodule

// File: rtl/knob_scanner.sv
// Continuously scans 12 front-panel potentiometers over two MCP3008 ADCs (indices 0-7 on ADC0,
// 8-11 on ADC1) and holds the latest 10-bit conversion of each one.
module knob_scanner
    import knob_pkg::*;
#(
    parameter int HALF_PERIOD = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cipo,
    output logic              copi,
    output logic              dclk,
    output logic              cs0,
    output logic              cs1,
    output logic [KNOB_W-1:0] volume,
    output logic [KNOB_W-1:0] pitch,
    output logic [KNOB_W-1:0] delay_wet,
    output logic [KNOB_W-1:0] delay_rate,
    output logic [KNOB_W-1:0] delay_feedback,
    output logic [KNOB_W-1:0] reverb_wet,
    output logic [KNOB_W-1:0] reverb_size,
    output logic [KNOB_W-1:0] reverb_feedback,
    output logic [KNOB_W-1:0] filter_quality,
    output logic [KNOB_W-1:0] filter_cutoff,
    output logic [KNOB_W-1:0] distortion_drive,
    output logic [KNOB_W-1:0] crush_pressure,
    output logic              frame_done
);

    localparam logic [3:0] LAST_KNOB = 4'(NUM_KNOBS - 1);

    logic [3:0]        k_q;
    logic [KNOB_W-1:0] knob_q [NUM_KNOBS];
    logic [KNOB_W-1:0] xfer_result;
    logic              xfer_done;

    // The scan never pauses, so the transfer engine is always asked to start again.
    mcp3008_xfer #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_xfer (
        .clk     (clk),
        .rst     (rst),
        .start   (1'b1),
        .dev_sel (k_q[3]),
        .channel (k_q[2:0]),
        .cipo    (cipo),
        .result  (xfer_result),
        .done    (xfer_done),
        .copi    (copi),
        .dclk    (dclk),
        .cs0     (cs0),
        .cs1     (cs1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q        <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < NUM_KNOBS; i++) begin
                knob_q[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            if (xfer_done) begin
                knob_q[k_q] <= xfer_result;
                frame_done  <= (k_q == LAST_KNOB);
                k_q         <= (k_q == LAST_KNOB) ? '0 : k_q + 4'd1;
            end
        end
    end

    assign volume           = knob_q[KNOB_VOLUME];
    assign pitch            = knob_q[KNOB_PITCH];
    assign delay_wet        = knob_q[KNOB_DELAY_WET];
    assign delay_rate       = knob_q[KNOB_DELAY_RATE];
    assign delay_feedback   = knob_q[KNOB_DELAY_FEEDBACK];
    assign reverb_wet       = knob_q[KNOB_REVERB_WET];
    assign reverb_size      = knob_q[KNOB_REVERB_SIZE];
    assign reverb_feedback  = knob_q[KNOB_REVERB_FEEDBACK];
    assign filter_quality   = knob_q[KNOB_FILTER_QUALITY];
    assign filter_cutoff    = knob_q[KNOB_FILTER_CUTOFF];
    assign distortion_drive = knob_q[KNOB_DIST_DRIVE];
    assign crush_pressure   = knob_q[KNOB_CRUSH_PRESSURE];

endmodule
